serial_frame_receiver: RTL

Receiving end of the team's serial shift-register link. It deserializes a framed bitstream on `sin` into `DATA_W`-bit words, checks framing and, optionally, parity. Each good word goes into a one-entry output buffer with a valid/ready handshake. It sits downstream of the PISO/SISO-L transmitter path and reconstructs the parallel word that was shifted out MSB-first.

---
 rtl/serial_link_pkg.sv | 15 +
 rtl/sipo_shifter.sv | 30 +++
 rtl/serial_frame_receiver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial shift-register link (transmit and receive sides).
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/sipo_shifter.sv
// Serial-in parallel-out shift-left register with synchronous clear and running
// even-parity accumulator over every bit shifted in since the last clear.
module sipo_shifter #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_shift_en,
  input  logic              i_sin,
  output logic [DATA_W-1:0] o_data,
  output logic              o_parity
);

  logic [DATA_W-1:0] r_data;
  logic              r_parity;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_data   <= '0;
      r_parity <= 1'b0;
    end else if (i_shift_en) begin
      r_data   <= {r_data[DATA_W-2:0], i_sin};
      r_parity <= r_parity ^ i_sin;
    end
  end

  assign o_data   = r_data;
  assign o_parity = r_parity;

endmodule

// File: rtl/serial_frame_receiver.sv
// Framed serial receiver with a one-entry valid/ready output buffer.
// Optional even parity bit enabled by defining SERIAL_RX_PARITY_EN.
module serial_frame_receiver
  import serial_link_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  rx_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_start, w_shift, w_eval, w_par_bad, w_xfer;
  logic [DATA_W-1:0] w_data;
  logic              w_run_par;

  logic [DATA_W-1:0] r_dout;
  logic              r_valid, r_frame_err, r_parity_err, r_overrun;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_eval      = 1'b0;
    if (bit_en) begin
      case (r_state)
        IDLE: begin
          if (sin == START_BIT) begin
            w_start     = 1'b1;
            w_state_nxt = DATA;
          end
        end
        DATA: begin
          w_shift = 1'b1;
          if (r_cnt == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: w_state_nxt = STOP;
`endif
        STOP: begin
          w_eval      = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_start) r_cnt <= '0;
    else if (w_shift)     r_cnt <= r_cnt + 1'b1;
  end

  // Clearing on the start bit keeps bits of an aborted frame out of the next word.
  sipo_shifter #(
    .DATA_W(DATA_W)
  ) u_shifter (
    .clk       (clk),
    .i_clr     (reset || w_start),
    .i_shift_en(w_shift),
    .i_sin     (sin),
    .o_data    (w_data),
    .o_parity  (w_run_par)
  );

`ifdef SERIAL_RX_PARITY_EN
  logic r_par_bit;

  always_ff @(posedge clk) begin
    if (reset)                              r_par_bit <= 1'b0;
    else if (bit_en && r_state == PARITY)   r_par_bit <= sin;
  end

  assign w_par_bad = w_run_par ^ r_par_bit;
`else
  logic w_unused_par;
  assign w_unused_par = w_run_par;
  assign w_par_bad    = 1'b0;
`endif

  assign w_xfer = r_valid && dout_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      if (w_xfer) r_valid <= 1'b0;
      if (w_eval) begin
        if (sin != STOP_BIT) begin
          r_frame_err <= 1'b1;
        end else if (w_par_bad) begin
          r_parity_err <= 1'b1;
        end else if (r_valid && !w_xfer) begin
          r_overrun <= 1'b1;
        end else begin
          r_dout  <= w_data;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign frame_err  = r_frame_err;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif
  assign overrun    = r_overrun;

endmodule
